mult_pipe_fu: RTL and testbench

//  Pipelined integer multiply functional unit in the EX stage, fed by the issue stage's mul lane.

---
 rtl/mult_pipe_fu.sv | 142 ++++++++++++++
 tb/tb_mult_pipe_fu.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe_fu.sv
// mult_pipe_fu: pipelined RV32M integer multiply unit (MUL/MULH/MULHSU/MULHU).
// The product is built as STAGES partial-product accumulations of CH-bit chunks of opb.
// Build option MULT_BUBBLE_COLLAPSE_EN: per-stage advance, so bubbles are squeezed out
// behind a stalled output. When it is undefined, one global advance moves the whole pipe.
module mult_pipe_fu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned ROB_W  = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rollback_en,
  input  logic             in_valid,
  input  logic [1:0]       in_func,
  input  logic [XLEN-1:0]  in_opa,
  input  logic [XLEN-1:0]  in_opb,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [ROB_W-1:0] in_rob_idx,
  output logic             in_ready,
  output logic             stall_mul,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [ROB_W-1:0] out_rob_idx,
  input  logic             out_ack
);

  localparam int unsigned DW = 2 * XLEN;
  localparam int unsigned CH = DW / STAGES;

  // Stage payload registers, indexed 1 (entry) .. STAGES (final / output)
  logic [STAGES:1]  r_v;
  logic [DW-1:0]    r_acc  [1:STAGES];
  logic [DW-1:0]    r_opa  [1:STAGES];
  logic [DW-1:0]    r_opb  [1:STAGES];
  logic [1:0]       r_func [1:STAGES];
  logic [TAG_W-1:0] r_tag  [1:STAGES];
  logic [ROB_W-1:0] r_rob  [1:STAGES];

  // Values each stage would load this edge (from the issue port or the stage before)
  logic [STAGES:1]  w_src_v;
  logic [DW-1:0]    w_src_acc  [1:STAGES];
  logic [DW-1:0]    w_src_a    [1:STAGES];
  logic [DW-1:0]    w_src_b    [1:STAGES];
  logic [1:0]       w_src_func [1:STAGES];
  logic [TAG_W-1:0] w_src_tag  [1:STAGES];
  logic [ROB_W-1:0] w_src_rob  [1:STAGES];
  logic [DW-1:0]    w_nxt_acc  [1:STAGES];
  logic [STAGES:1]  w_ld;
  logic [STAGES:1]  w_v_nxt;

  logic             w_sa;
  logic             w_sb;
  logic [DW-1:0]    w_opa_ext;
  logic [DW-1:0]    w_opb_ext;

  // Operand extension: opa signed except MULHU, opb signed only for MUL/MULH
  assign w_sa      = (in_func != 2'd3);
  assign w_sb      = ~in_func[1];
  assign w_opa_ext = {{XLEN{w_sa & in_opa[XLEN-1]}}, in_opa};
  assign w_opb_ext = {{XLEN{w_sb & in_opb[XLEN-1]}}, in_opb};

  // Stage load enables: a stage loads when its content can leave (or it is empty)
  assign w_ld[STAGES] = out_ack | ~r_v[STAGES];

  genvar g;
  generate
    for (g = 1; g < STAGES; g++) begin : g_ld
`ifdef MULT_BUBBLE_COLLAPSE_EN
      // Any empty slot at or after this stage lets everything upstream of it move
      assign w_ld[g] = out_ack | ~(&r_v[STAGES:g]);
`else
      assign w_ld[g] = w_ld[STAGES];
`endif
    end

    for (g = 1; g <= STAGES; g++) begin : g_stage
      if (g == 1) begin : g_first
        // Entry stage takes the extended operands straight from issue
        assign w_src_v[g]    = in_valid;
        assign w_src_acc[g]  = '0;
        assign w_src_a[g]    = w_opa_ext;
        assign w_src_b[g]    = w_opb_ext;
        assign w_src_func[g] = in_func;
        assign w_src_tag[g]  = in_tag;
        assign w_src_rob[g]  = in_rob_idx;
      end else begin : g_rest
        assign w_src_v[g]    = r_v[g-1];
        assign w_src_acc[g]  = r_acc[g-1];
        assign w_src_a[g]    = r_opa[g-1];
        assign w_src_b[g]    = r_opb[g-1];
        assign w_src_func[g] = r_func[g-1];
        assign w_src_tag[g]  = r_tag[g-1];
        assign w_src_rob[g]  = r_rob[g-1];
      end

      // Accumulate this stage's chunk of opb, shifted into place, mod 2^DW
      assign w_nxt_acc[g] = w_src_acc[g]
                          + ((w_src_a[g] * DW'(w_src_b[g][(g-1)*CH +: CH])) << ((g-1)*CH));

      assign w_v_nxt[g] = w_ld[g] ? w_src_v[g] : r_v[g];

      // Per-stage payload register; holds while the stage is stalled
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          r_acc[g]  <= '0;
          r_opa[g]  <= '0;
          r_opb[g]  <= '0;
          r_func[g] <= '0;
          r_tag[g]  <= '0;
          r_rob[g]  <= '0;
        end else if (w_ld[g]) begin
          r_acc[g]  <= w_nxt_acc[g];
          r_opa[g]  <= w_src_a[g];
          r_opb[g]  <= w_src_b[g];
          r_func[g] <= w_src_func[g];
          r_tag[g]  <= w_src_tag[g];
          r_rob[g]  <= w_src_rob[g];
        end
      end
    end
  endgenerate

  // Valid bits: rollback drops everything in flight, including a same-cycle accept
  always_ff @(posedge clock) begin
    if (!reset_n || rollback_en) begin
      r_v <= '0;
    end else begin
      r_v <= w_v_nxt;
    end
  end

  assign in_ready    = w_ld[1];
  assign stall_mul   = ~w_ld[1];
  assign out_valid   = r_v[STAGES];
  assign out_tag     = r_tag[STAGES];
  assign out_rob_idx = r_rob[STAGES];
  assign out_result  = (r_func[STAGES] == 2'd0) ? r_acc[STAGES][XLEN-1:0]
                                                : r_acc[STAGES][DW-1:XLEN];

endmodule

// File: tb/tb_mult_pipe_fu.sv
// tb_mult_pipe_fu: random + directed bench for mult_pipe_fu against a queue-based
// position model of in-flight ops. Honours MULT_BUBBLE_COLLAPSE_EN like the DUT.
module tb_mult_pipe_fu;

  localparam int S = 4;

  logic        clock;
  logic        reset_n;
  logic        rollback_en;
  logic        in_valid;
  logic [1:0]  in_func;
  logic [31:0] in_opa;
  logic [31:0] in_opb;
  logic [5:0]  in_tag;
  logic [4:0]  in_rob_idx;
  logic        in_ready;
  logic        stall_mul;
  logic        out_valid;
  logic [31:0] out_result;
  logic [5:0]  out_tag;
  logic [4:0]  out_rob_idx;
  logic        out_ack;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
    logic [4:0]  rob;
    int          pos;
  } item_t;

  item_t q[$];

  mult_pipe_fu #(.XLEN(32), .STAGES(S), .TAG_W(6), .ROB_W(5)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rollback_en(rollback_en),
    .in_valid   (in_valid),
    .in_func    (in_func),
    .in_opa     (in_opa),
    .in_opb     (in_opb),
    .in_tag     (in_tag),
    .in_rob_idx (in_rob_idx),
    .in_ready   (in_ready),
    .stall_mul  (stall_mul),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_rob_idx(out_rob_idx),
    .out_ack    (out_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural result of an RV32M multiply
  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f != 2'd3 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    eb = (f <  2'd2 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p  = ea * eb;
    return (f == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic model_ready(input logic ack);
`ifdef MULT_BUBBLE_COLLAPSE_EN
    return ack || (q.size() < S);
`else
    return ack || !(q.size() > 0 && q[0].pos == S);
`endif
  endfunction

  // Move in-flight ops one edge forward (positions 1..S, S = output stage)
  task automatic model_edge(input logic ack, input logic rb, input logic acc, input item_t nw);
    item_t nq[$];
    int    ahead;
    int    np;
    if (rb) begin
      q.delete();
      return;
    end
`ifdef MULT_BUBBLE_COLLAPSE_EN
    ahead = S + 1;
    foreach (q[i]) begin
      if (q[i].pos == S) begin
        if (ack) continue;
        ahead = S;
        nq.push_back(q[i]);
      end else begin
        np = q[i].pos + 1;
        if (np >= ahead) np = ahead - 1;
        ahead = np;
        nq.push_back(q[i]);
        nq[nq.size()-1].pos = np;
      end
    end
    q = nq;
`else
    if (!(q.size() > 0 && q[0].pos == S) || ack) begin
      if (q.size() > 0 && q[0].pos == S) void'(q.pop_front());
      foreach (q[i]) q[i].pos = q[i].pos + 1;
    end
`endif
    if (acc) q.push_back(nw);
  endtask

  task automatic check_outputs();
    logic exp_v;
    exp_v = (q.size() > 0 && q[0].pos == S);
    check("out_valid", out_valid, exp_v);
    if (exp_v) begin
      check("out_result", out_result, q[0].res);
      check("out_tag", out_tag, q[0].tag);
      check("out_rob_idx", out_rob_idx, q[0].rob);
    end
  endtask

  // One clock cycle: starts and ends at a negedge
  task automatic cycle(input logic v, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] t, input logic [4:0] r,
                       input logic ack, input logic rb, input logic [31:0] exp_res);
    logic  exp_rdy;
    logic  acc;
    item_t nw;
    in_valid = v; in_func = f; in_opa = a; in_opb = b; in_tag = t; in_rob_idx = r;
    out_ack = ack; rollback_en = rb;
    #1;
    exp_rdy = model_ready(ack);
    check("in_ready", in_ready, exp_rdy);
    check("stall_mul", stall_mul, !exp_rdy);
    acc = v && exp_rdy && !rb;
    nw.res = exp_res; nw.tag = t; nw.rob = r; nw.pos = 1;
    @(posedge clock);
    model_edge(ack, rb, acc, nw);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [5:0] t, input logic [4:0] r, input logic ack);
    cycle(1'b1, f, a, b, t, r, ack, 1'b0, ref_mul(f, a, b));
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 32'd0, 32'd0, 6'd0, 5'd0, ack, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ack = 1'b0; rollback_en = 1'b0;
    @(posedge clock);
    q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_tag", out_tag, 6'd0);
    check("rst_out_rob_idx", out_rob_idx, 5'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0; rollback_en = 1'b0; in_valid = 1'b0; in_func = 2'd0;
    in_opa = '0; in_opb = '0; in_tag = '0; in_rob_idx = '0; out_ack = 1'b0;
    @(posedge clock);
    @(negedge clock);
    do_reset();

    // Basic MUL with tag/rob echo
    cycle(1'b1, 2'd0, 32'd7, 32'd6, 6'd5, 5'd3, 1'b1, 1'b0, 32'd42);
    idle(S + 1, 1'b1);

    // Signedness corners with all-ones operands
    cycle(1'b1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, 5'd1, 1'b1, 1'b0, 32'h0000_0000);
    cycle(1'b1, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 5'd2, 1'b1, 1'b0, 32'hFFFF_FFFE);
    cycle(1'b1, 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3, 5'd3, 1'b1, 1'b0, 32'hFFFF_FFFF);
    cycle(1'b1, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd4, 5'd4, 1'b1, 1'b0, 32'h0000_0001);
    idle(S + 1, 1'b1);

    // Back-to-back MULs at full throughput
    for (int i = 0; i < 4; i++) op(2'd0, 32'(i + 3), 32'(i + 10), 6'(10 + i), 5'(i), 1'b1);
    idle(S + 1, 1'b1);

    // Output back-pressure with one op in flight, then more ops queued behind it
    op(2'd0, 32'd11, 32'd13, 6'd20, 5'd7, 1'b0);
    idle(S + 2, 1'b0);
    op(2'd1, 32'h8000_0000, 32'h7FFF_FFFF, 6'd21, 5'd8, 1'b0);
    op(2'd2, 32'hDEAD_BEEF, 32'h1234_5678, 6'd22, 5'd9, 1'b0);
    idle(2, 1'b0);
    idle(S + 4, 1'b1);

    // Rollback while three ops are in flight; the same-cycle input is dropped
    op(2'd0, 32'd2, 32'd3, 6'd30, 5'd10, 1'b1);
    op(2'd0, 32'd4, 32'd5, 6'd31, 5'd11, 1'b1);
    op(2'd0, 32'd6, 32'd7, 6'd32, 5'd12, 1'b1);
    cycle(1'b1, 2'd0, 32'd8, 32'd9, 6'd33, 5'd13, 1'b1, 1'b1, 32'd72);
    idle(S + 1, 1'b1);
    op(2'd3, 32'hFFFF_0000, 32'h0001_0000, 6'd34, 5'd14, 1'b1);
    idle(S + 1, 1'b1);

    // Reset mid-pipe
    op(2'd0, 32'd100, 32'd200, 6'd40, 5'd15, 1'b1);
    op(2'd1, 32'h9999_9999, 32'h5555_5555, 6'd41, 5'd16, 1'b1);
    do_reset();
    idle(S + 1, 1'b1);

    // Random traffic with back-pressure, rollbacks and occasional resets
    for (int c = 0; c < 3000; c++) begin
      logic        v, ack, rb;
      logic [1:0]  f;
      logic [31:0] a, b;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        v   = ($urandom_range(0, 3) != 0);
        ack = ($urandom_range(0, 3) != 0);
        rb  = ($urandom_range(0, 39) == 0);
        f   = 2'($urandom_range(0, 3));
        a   = pick_operand();
        b   = pick_operand();
        cycle(v, f, a, b, 6'($urandom), 5'($urandom), ack, rb, ref_mul(f, a, b));
      end
    end
    idle(S + 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
